conflict_free_memory_unmap: RTL and testbench

CONFLICT_FREE_MEMORY_UNMAP -- requirements
Module: conflict_free_memory_unmap

---
 rtl/conflict_free_memory_unmap_if.sv | 48 ++++
 rtl/conflict_free_memory_unmap.sv | 178 +++++++++++++++++
 tb/tb_conflict_free_memory_unmap.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/conflict_free_memory_unmap_if.sv
// Bus bundle for conflict_free_memory_unmap: start/status, the four bank
// read ports and the ready/valid output stream.
// The slave modport is the unmap block; the master modport is its environment.
interface conflict_free_memory_unmap_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [4:0]            rd_addr_0;
    logic [4:0]            rd_addr_1;
    logic [4:0]            rd_addr_2;
    logic [4:0]            rd_addr_3;
    logic [DATA_WIDTH-1:0] bank_rdata_0;
    logic [DATA_WIDTH-1:0] bank_rdata_1;
    logic [DATA_WIDTH-1:0] bank_rdata_2;
    logic [DATA_WIDTH-1:0] bank_rdata_3;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data_0;
    logic [DATA_WIDTH-1:0] out_data_1;
    logic [DATA_WIDTH-1:0] out_data_2;
    logic [DATA_WIDTH-1:0] out_data_3;
    logic [4:0]            out_index;

    modport slave (
        input  start,
        output busy, done, rd_en,
        output rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3,
        input  bank_rdata_0, bank_rdata_1, bank_rdata_2, bank_rdata_3,
        output out_valid,
        input  out_ready,
        output out_data_0, out_data_1, out_data_2, out_data_3,
        output out_index
    );

    modport master (
        output start,
        input  busy, done, rd_en,
        input  rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3,
        output bank_rdata_0, bank_rdata_1, bank_rdata_2, bank_rdata_3,
        input  out_valid,
        output out_ready,
        input  out_data_0, out_data_1, out_data_2, out_data_3,
        input  out_index
    );
endinterface

// File: rtl/conflict_free_memory_unmap.sv
// conflict_free_memory_unmap: reads 128 coefficients stored across four banks
// with a rotating (skewed) bank assignment and returns them in natural order,
// four lanes per group, through a 2-entry output FIFO.
// Optional build macro CFMU_BITREV_ORDER_EN: when defined, groups are issued
// in 5-bit bit-reversed order; out_index always carries the real group.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; start is only honoured here
// ST_RUN   | issuing group reads, throttled by FIFO space
// ST_DRAIN | all 32 groups issued, waiting for group 31 to be accepted
module conflict_free_memory_unmap #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    conflict_free_memory_unmap_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [4:0]            grp;
    logic [1:0]            skew;
    logic                  rd_en;
    logic                  inflight_q;
    logic [4:0]            grp_q;
    logic [1:0]            skew_q;
    logic [2:0]            occupancy;

    logic [DATA_WIDTH-1:0] rdata [4];
    logic [DATA_WIDTH-1:0] lane_d [4];
    logic [DATA_WIDTH-1:0] fifo_data_q [2][4];
    logic [4:0]            fifo_idx_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            fcnt_q, fcnt_d;
    logic                  push, pop;
    logic                  out_valid;
    logic [4:0]            head_idx;

`ifdef CFMU_BITREV_ORDER_EN
    assign grp = {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3], cnt_q[4]};
`else
    assign grp = cnt_q[4:0];
`endif

    // Rotation of the group: lane j lives in bank (skew + j) mod 4.
    assign skew = 2'({1'b0, grp[4]} + grp[3:2] + grp[1:0]);

    assign out_valid = (fcnt_q != 2'd0);
    assign pop       = out_valid & bus.out_ready;
    assign push      = inflight_q;
    assign head_idx  = fifo_idx_q[rd_ptr_q];

    // Entries that will be held once everything already requested lands;
    // a new read is only issued if that still leaves a free slot.
    assign occupancy = {1'b0, fcnt_q} - {2'b00, pop} + {2'b00, inflight_q};
    assign rd_en     = (state_q == ST_RUN) && (occupancy < 3'd2);

    assign rdata[0] = bus.bank_rdata_0;
    assign rdata[1] = bus.bank_rdata_1;
    assign rdata[2] = bus.bank_rdata_2;
    assign rdata[3] = bus.bank_rdata_3;

    // Undo the bank rotation using the skew that travelled with the read.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            lane_d[j] = rdata[skew_q + 2'(j)];
        end
    end

    // Sequencer next-state: group counter never wraps, exit on group 31 handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    cnt_d   = 6'd0;
                end
            end
            ST_RUN: begin
                if (rd_en) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && (head_idx == 5'd31)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO occupancy next-state.
    always_comb begin
        fcnt_d = fcnt_q;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 2'd1;
            2'b01:   fcnt_d = fcnt_q - 2'd1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    // Sequencer state, group counter and the read pipeline tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            grp_q      <= 5'd0;
            skew_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            inflight_q <= rd_en;
            if (rd_en) begin
                grp_q  <= grp;
                skew_q <= skew;
            end
        end
    end

    // Two-entry output FIFO holding de-rotated lanes and their group index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fcnt_q   <= 2'd0;
            for (int e = 0; e < 2; e++) begin
                fifo_idx_q[e] <= 5'd0;
                for (int j = 0; j < 4; j++) begin
                    fifo_data_q[e][j] <= '0;
                end
            end
        end else begin
            fcnt_q <= fcnt_d;
            if (push) begin
                wr_ptr_q             <= ~wr_ptr_q;
                fifo_idx_q[wr_ptr_q] <= grp_q;
                for (int j = 0; j < 4; j++) begin
                    fifo_data_q[wr_ptr_q][j] <= lane_d[j];
                end
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.rd_en      = rd_en;
    assign bus.rd_addr_0  = grp;
    assign bus.rd_addr_1  = grp;
    assign bus.rd_addr_2  = grp;
    assign bus.rd_addr_3  = grp;
    assign bus.out_valid  = out_valid;
    assign bus.out_index  = head_idx;
    assign bus.out_data_0 = fifo_data_q[rd_ptr_q][0];
    assign bus.out_data_1 = fifo_data_q[rd_ptr_q][1];
    assign bus.out_data_2 = fifo_data_q[rd_ptr_q][2];
    assign bus.out_data_3 = fifo_data_q[rd_ptr_q][3];

endmodule

// File: tb/tb_conflict_free_memory_unmap.sv
// Directed bench for conflict_free_memory_unmap: preloaded skewed banks,
// full read-outs under steady, stalled and patterned out_ready, reset abort
// and start-while-busy.
module tb_conflict_free_memory_unmap;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conflict_free_memory_unmap_if #(.DATA_WIDTH(DW)) bus ();
    conflict_free_memory_unmap #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int c_start = 0;
    int xfer_n, issue_n, done_n, first_c, last_c, done_c;
    logic [DW-1:0] bank_mem [4][32];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int exp_order(input int k);
        int g;
        int r;
        g = k & 31;
        r = g;
`ifdef CFMU_BITREV_ORDER_EN
        r = 0;
        for (int b = 0; b < 5; b++) if (((g >> b) & 1) != 0) r = r | (1 << (4 - b));
`endif
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: one-cycle read latency, poison value when not enabled.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.bank_rdata_0 <= bank_mem[0][bus.rd_addr_0];
            bus.bank_rdata_1 <= bank_mem[1][bus.rd_addr_1];
            bus.bank_rdata_2 <= bank_mem[2][bus.rd_addr_2];
            bus.bank_rdata_3 <= bank_mem[3][bus.rd_addr_3];
        end else begin
            bus.bank_rdata_0 <= 16'hBAD0;
            bus.bank_rdata_1 <= 16'hBAD1;
            bus.bank_rdata_2 <= 16'hBAD2;
            bus.bank_rdata_3 <= 16'hBAD3;
        end
    end

    // Monitor: issues, transfers and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        int rel;
        rel = cyc - c_start + 1;
        if (bus.rd_en) begin
            chk("rd_addr_0", int'(bus.rd_addr_0), exp_order(issue_n));
            chk("rd_addr_1", int'(bus.rd_addr_1), exp_order(issue_n));
            chk("rd_addr_2", int'(bus.rd_addr_2), exp_order(issue_n));
            chk("rd_addr_3", int'(bus.rd_addr_3), exp_order(issue_n));
            issue_n++;
        end
        if (bus.out_valid && bus.out_ready) begin
            if (xfer_n == 0) first_c = rel;
            last_c = rel;
            chk("out_index", int'(bus.out_index), exp_order(xfer_n));
            chk("out_data_0", int'(bus.out_data_0), 4 * int'(bus.out_index) + 0);
            chk("out_data_1", int'(bus.out_data_1), 4 * int'(bus.out_index) + 1);
            chk("out_data_2", int'(bus.out_data_2), 4 * int'(bus.out_index) + 2);
            chk("out_data_3", int'(bus.out_data_3), 4 * int'(bus.out_index) + 3);
            xfer_n++;
        end
        if (bus.done) begin
            done_n++;
            done_c = rel;
            chk("busy_at_done", int'(bus.busy), 0);
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
        chk({tag, "_rd_addr"}, int'(bus.rd_addr_0) + int'(bus.rd_addr_1)
                               + int'(bus.rd_addr_2) + int'(bus.rd_addr_3), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_out_data"}, int'(bus.out_data_0) + int'(bus.out_data_1)
                                + int'(bus.out_data_2) + int'(bus.out_data_3), 0);
        chk({tag, "_out_index"}, int'(bus.out_index), 0);
    endtask

    // Pulse start for one edge (E0); afterwards we sit 1 time unit into cycle 1.
    task automatic pulse_start();
        xfer_n = 0; issue_n = 0; done_n = 0;
        first_c = -1; last_c = -1; done_c = -1;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        c_start = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_n == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", int'(done_n > 0), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input string tag, input int extra, input bit timing);
        chk({tag, "_xfers"}, xfer_n, 32);
        chk({tag, "_issues"}, issue_n, 32);
        chk({tag, "_done_cnt"}, done_n, 1);
        chk({tag, "_busy_end"}, int'(bus.busy), 0);
        if (timing) begin
            chk({tag, "_first_xfer"}, first_c, 3);
            chk({tag, "_last_xfer"}, last_c, 34 + extra);
            chk({tag, "_done_cycle"}, done_c, 35 + extra);
        end
    endtask

    initial begin
        int n;
        int iss0;
        logic [15:0] pat;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        for (int a = 0; a < 128; a++) begin
            int bk;
            bk = (((a >> 6) & 1) + ((a >> 4) & 3) + ((a >> 2) & 3) + (a & 3)) % 4;
            bank_mem[bk][a >> 2] = DW'(a);
        end
        #1;
        check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Full read-out with out_ready held high, plus first-issue addressing.
        bus.out_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        chk("c1_rd_en", int'(bus.rd_en), 1);
        chk("c1_busy", int'(bus.busy), 1);
        chk("c1_out_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("c2_rd_addr_0", int'(bus.rd_addr_0), exp_order(1));
        chk("c2_rd_addr_3", int'(bus.rd_addr_3), exp_order(1));
        wait_done(200);
        check_run("steady", 0, 1'b1);

        // Ten-cycle stall while group 5 is at the head.
        pulse_start();
        n = 0;
        while (!(bus.out_valid && bus.out_index == 5'd5) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_at", cyc - c_start + 1, 3 + exp_order(5));
        bus.out_ready = 1'b0;
        iss0 = issue_n;
        repeat (10) @(posedge clk);
        #1;
        chk("stall_issues", issue_n - iss0, 0);
        chk("stall_valid", int'(bus.out_valid), 1);
        chk("stall_head", int'(bus.out_index), 5);
        bus.out_ready = 1'b1;
        wait_done(200);
        check_run("stall", 10, 1'b1);

        // Reset while group 10 is presented: abort, no done, then clean rerun.
        pulse_start();
        n = 0;
        while (!(bus.out_valid && bus.out_index == 5'd10) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_found_g10", int'(bus.out_index), 10);
        rst = 1'b0;
        #1;
        check_zero_outputs("abort");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_n, 0);
        pulse_start();
        wait_done(200);
        check_run("rerun", 0, 1'b1);

        // start pulsed at cycle 10 of a running read-out must be ignored.
        pulse_start();
        repeat (9) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(200);
        check_run("restart_ignored", 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("restart_idle", int'(bus.busy), 0);

        // Irregular out_ready pattern: order and data must survive any backpressure.
        pat = 16'b1011_0010_1110_0101;
        pulse_start();
        n = 0;
        while (done_n == 0 && n < 400) begin
            bus.out_ready = pat[n % 16];
            @(posedge clk); #1;
            n++;
        end
        bus.out_ready = 1'b1;
        wait_done(10);
        check_run("pattern", 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
